pipeline_control: RTL and testbench
===================================

# pipeline_control

Sequencing controller for the five-stage MIPS pipeline. It consumes the hazard-detection outputs (load-use stall request and HALT decode) plus branch/jump flush requests and run/step/clear commands from the debug unit. From these it drives every per-stage register enable, the IF/ID flush and the ID/EX bubble insert. It also drains the pipeline after HALT and keeps an executed-cycle counter for the debug unit.

## Interface
- PIPE_DEPTH, 5, number of pipeline stages; drain length = PIPE_DEPTH-1 cycles
- CNT_WIDTH, 32, width of cycle counter
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_run  in  1  debug command: continuous execution (level sampled each edge)
- i_step  in  1  debug command: advance pipeline exactly one cycle
- i_clear  in  1  debug command: abort and return to IDLE, clears cycle counter
- i_load_hazard  in  1  stall request from hazard unit (IF/ID must hold, ID/EX gets bubble)
- i_halt  in  1  HALT opcode present in IF/ID
- i_jump_flush  in  1  branch/jump taken in ID; discard instruction in IF/ID
- o_pc_en  out  1  PC register write enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID synchronous clear to NOP
- o_id_ex_en  out  1  ID/EX register enable
- o_id_ex_bubble  out  1  load NOP/zero control into ID/EX instead of decoded word
- o_ex_mem_en  out  1  EX/MEM register enable
- o_mem_wb_en  out  1  MEM/WB register enable
- o_state  out  3  current state encoding
- o_halted  out  1  high while in HALTED
- o_cycle_count  out  CNT_WIDTH  cycles executed since reset/clear

## Operation
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; encodings 5-7 unreachable and recover to IDLE.
- Priority of transitions from any state: i_clear (-> IDLE) > halt handling > i_run > i_step.
- IDLE: i_run -> RUN; else i_step -> STEP; both high -> RUN.
- RUN: i_halt -> DRAIN; stays in RUN otherwise. i_run is not required to stay high.
- STEP: one advancing cycle, then IDLE; i_halt during that cycle -> DRAIN.
- DRAIN: drain counter loaded with PIPE_DEPTH-1 on entry, decremented every cycle; at count 1 -> HALTED.
- HALTED: holds until i_clear; i_run/i_step ignored.
- fetch_adv = state is RUN or STEP; back_adv = state is RUN, STEP or DRAIN.
- o_pc_en = o_if_id_en = fetch_adv & ~i_load_hazard & ~i_halt.
- o_if_id_flush = fetch_adv & i_jump_flush & ~i_load_hazard. A stall wins; the branch re-resolves next cycle.
- o_id_ex_bubble = (fetch_adv & i_load_hazard) | (state == DRAIN).
- o_id_ex_en = o_ex_mem_en = o_mem_wb_en = back_adv.
- o_halted = (state == HALTED); o_state = state register.
- Cycle counter increments by 1 on every edge where back_adv is high. It saturates at 2^CNT_WIDTH-1 with no wrap, and clears to 0 on i_clear.

## Timing
- Reset values: state IDLE, drain counter 0, cycle counter 0. All enables, o_if_id_flush, o_id_ex_bubble and o_halted are 0; o_state 0.
- Reset is asynchronous. Asserting it mid-RUN or mid-DRAIN forces all outputs to reset values immediately, without waiting for a clock edge.
- State, drain counter and cycle counter are registered.
- Enable, flush and bubble outputs are combinational from state and the current-cycle hazard inputs. They must be valid before the same edge that captures the pipeline registers.
- Command latency: i_run/i_step sampled high at edge N gives enables high during cycle N to N+1.
- A step yields exactly one cycle of back_adv.
- HALT: fetch stops in the same cycle i_halt is seen. DRAIN then lasts exactly PIPE_DEPTH-1 cycles with bubbles; o_halted rises on the following edge.
- i_clear in DRAIN aborts the drain immediately; no further enables are issued.

## Test plan
- Reset, then one i_step pulse: exactly one cycle with all enables = 1; returns to IDLE; o_cycle_count = 1.
- RUN with i_load_hazard high for 1 cycle: that cycle o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, back-end enables=1; counter still increments.
- RUN with i_jump_flush=1 and i_load_hazard=0: o_if_id_flush=1 for one cycle. With both high: flush=0 and bubble=1.
- RUN, i_halt at edge N: o_pc_en=0 from cycle N; state DRAIN for 4 cycles (PIPE_DEPTH=5) with bubble=1; o_halted=1 after the 4th. Later i_run is ignored; i_clear returns to IDLE with count=0.
- i_run and i_step high together in IDLE -> RUN. i_clear asserted in DRAIN -> IDLE next edge, all enables 0.
- CNT_WIDTH=4: run 20 cycles -> o_cycle_count saturates at 15. Async reset mid-RUN -> outputs 0 before the next edge.

Source files
------------

// File: rtl/pipeline_control.sv
// Sequencing controller for the five-stage pipeline: per-stage enables, IF/ID flush,
// ID/EX bubble, HALT drain and an executed-cycle counter for the debug unit.
//
// state  | meaning
// IDLE   | pipeline frozen, waiting for a run or step command
// RUN    | free-running, all stages advance
// STEP   | single advancing cycle, then back to IDLE
// DRAIN  | fetch stopped after HALT, back end flushes with bubbles
// HALTED | drained and frozen until cleared
module pipeline_control #(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_clear,
    input  logic                 i_load_hazard,
    input  logic                 i_halt,
    input  logic                 i_jump_flush,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_en,
    output logic                 o_id_ex_bubble,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic [2:0]           o_state,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);

    localparam int DRAIN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_cnt_nxt;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic                 fetch_adv;
    logic                 back_adv;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            cycle_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (i_clear)
                cycle_count <= '0;
            else if (back_adv && (cycle_count != {CNT_WIDTH{1'b1}}))
                cycle_count <= cycle_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = '0;
        fetch_adv      = 1'b0;
        back_adv       = 1'b0;
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;

        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_run)
                        state_nxt = RUN;
                    else if (i_step)
                        state_nxt = STEP;
                end
                RUN: begin
                    if (i_halt)
                        state_nxt = DRAIN;
                end
                STEP: begin
                    state_nxt = i_halt ? DRAIN : IDLE;
                end
                DRAIN: begin
                    // the cycle seen at count 1 is the last drain cycle
                    if (drain_cnt <= DRAIN_W'(1))
                        state_nxt = HALTED;
                end
                HALTED: state_nxt = HALTED;
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt == DRAIN)
            drain_cnt_nxt = (state == DRAIN) ? drain_cnt - 1'b1 : DRAIN_LOAD;

        fetch_adv = (state == RUN) || (state == STEP);
        back_adv  = fetch_adv || (state == DRAIN);

        o_pc_en        = fetch_adv & ~i_load_hazard & ~i_halt;
        o_if_id_en     = fetch_adv & ~i_load_hazard & ~i_halt;
        // a stall holds IF/ID, so the branch resolves again next cycle
        o_if_id_flush  = fetch_adv & i_jump_flush & ~i_load_hazard;
        o_id_ex_bubble = (fetch_adv & i_load_hazard) | (state == DRAIN);
        o_id_ex_en     = back_adv;
        o_ex_mem_en    = back_adv;
        o_mem_wb_en    = back_adv;
    end

    assign o_state       = state;
    assign o_halted      = (state == HALTED);
    assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control; a second instance with a 4-bit counter
// shares all inputs to exercise counter saturation.
module tb_pipeline_control;

    logic clk;
    logic rst;
    logic run, step, clear, load_hazard, halt, jump_flush;

    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
    logic [2:0] state;
    logic       halted;
    logic [31:0] cycle_count;

    logic       pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_bubble4, ex_mem_en4, mem_wb_en4;
    logic [2:0] state4;
    logic       halted4;
    logic [3:0] cycle_count4;

    logic [6:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_control #(.PIPE_DEPTH(5), .CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clear),
        .i_load_hazard(load_hazard), .i_halt(halt), .i_jump_flush(jump_flush),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_en(id_ex_en), .o_id_ex_bubble(id_ex_bubble), .o_ex_mem_en(ex_mem_en),
        .o_mem_wb_en(mem_wb_en), .o_state(state), .o_halted(halted),
        .o_cycle_count(cycle_count)
    );

    pipeline_control #(.PIPE_DEPTH(5), .CNT_WIDTH(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clear),
        .i_load_hazard(load_hazard), .i_halt(halt), .i_jump_flush(jump_flush),
        .o_pc_en(pc_en4), .o_if_id_en(if_id_en4), .o_if_id_flush(if_id_flush4),
        .o_id_ex_en(id_ex_en4), .o_id_ex_bubble(id_ex_bubble4), .o_ex_mem_en(ex_mem_en4),
        .o_mem_wb_en(mem_wb_en4), .o_state(state4), .o_halted(halted4),
        .o_cycle_count(cycle_count4)
    );

    // {pc, if_id, flush, id_ex, bubble, ex_mem, mem_wb}
    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {run, step, clear, load_hazard, halt, jump_flush} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'h00);
        check("rst_state", 32'(state), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", cycle_count, 32'd0);
        rst = 1'b0;

        // single step
        step = 1'b1;
        #1;
        check("idle_outs", 32'(outs), 32'h00);
        cyc();
        step = 1'b0;
        #1;
        check("step_state", 32'(state), 32'd2);
        check("step_outs", 32'(outs), 32'h6B);
        cyc();
        check("step_ret_state", 32'(state), 32'd0);
        check("step_ret_outs", 32'(outs), 32'h00);
        check("step_count", cycle_count, 32'd1);

        // run with a load-use stall, then jump flush
        run = 1'b1;
        cyc();
        run = 1'b0;
        #1;
        check("run_state", 32'(state), 32'd1);
        check("run_outs", 32'(outs), 32'h6B);
        cyc();
        load_hazard = 1'b1;
        #1;
        check("stall_outs", 32'(outs), 32'h0F);
        cyc();
        load_hazard = 1'b0;
        #1;
        check("stall_count", cycle_count, 32'd3);
        check("run_kept_state", 32'(state), 32'd1);
        jump_flush = 1'b1;
        #1;
        check("flush_outs", 32'(outs), 32'h7B);
        load_hazard = 1'b1;
        #1;
        check("flush_stall_outs", 32'(outs), 32'h0F);
        cyc();
        {load_hazard, jump_flush} = '0;

        // halt and drain
        halt = 1'b1;
        #1;
        check("halt_outs", 32'(outs), 32'h0B);
        cyc();
        halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("drain_state_%0d", k), 32'(state), 32'd3);
            check($sformatf("drain_outs_%0d", k), 32'(outs), 32'h0F);
            cyc();
        end
        check("halted_state", 32'(state), 32'd4);
        check("halted_flag", 32'(halted), 32'd1);
        check("halted_outs", 32'(outs), 32'h00);
        check("halted_count", cycle_count, 32'd9);
        run  = 1'b1;
        step = 1'b1;
        cyc();
        check("halted_ignore_run", 32'(state), 32'd4);
        check("halted_hold_count", cycle_count, 32'd9);
        run   = 1'b0;
        step  = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        #1;
        check("clear_state", 32'(state), 32'd0);
        check("clear_count", cycle_count, 32'd0);
        check("clear_halted", 32'(halted), 32'd0);

        // run+step together, then clear aborts a drain
        run  = 1'b1;
        step = 1'b1;
        cyc();
        run  = 1'b0;
        step = 1'b0;
        #1;
        check("run_step_state", 32'(state), 32'd1);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        cyc();
        check("abort_in_drain", 32'(state), 32'd3);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_outs", 32'(outs), 32'h00);
        check("abort_count", cycle_count, 32'd0);
        cyc();
        check("abort_stays_idle", 32'(state), 32'd0);
        check("abort_stays_outs", 32'(outs), 32'h00);

        // saturation on the 4-bit counter
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (20) cyc();
        check("count32_20", cycle_count, 32'd20);
        check("count4_sat", 32'(cycle_count4), 32'd15);
        check("state4_run", 32'(state4), 32'd1);

        // async reset mid-run, checked well before the next edge
        rst = 1'b1;
        #1;
        check("async_outs", 32'(outs), 32'h00);
        check("async_state", 32'(state), 32'd0);
        check("async_count", cycle_count, 32'd0);
        check("async_count4", 32'(cycle_count4), 32'd0);
        #2;
        rst = 1'b0;
        cyc();
        check("post_reset_idle", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
